// File: rtl/wb_select_stage.sv
// wb_select_stage
//   Registered writeback-select stage. Picks one of NSRC result sources at
//   accept time and carries the destination register address and a
//   qualified write enable alongside it. A main register (M) drives the
//   outputs and a one-entry skid register (S) catches a beat when the
//   register file stalls. in_ready therefore comes straight from a flop.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   sel                  source index for the offered beat
//   src_data             NSRC flattened sources, source k at [k*N +: N]
//   rd_addr, wr_en_in    destination register and write request
//   out_valid/out_ready  downstream (register-file) handshake
//   out_data             selected value (0 when sel is out of range)
//   out_addr             destination register
//   out_wr_en            write enable, suppressed for R0 and bad selects
//   out_err              beat carried sel >= NSRC
module wb_select_stage #(
    parameter  int N    = 16,
    parameter  int NSRC = 4,
    parameter  int AW   = 4,
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   sel,
    input  logic [NSRC*N-1:0] src_data,
    input  logic [AW-1:0]     rd_addr,
    input  logic              wr_en_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [AW-1:0]     out_addr,
    output logic              out_wr_en,
    output logic              out_err
);

    localparam int unsigned NSRC_U = NSRC;

    typedef struct packed {
        logic          valid;
        logic [N-1:0]  data;
        logic [AW-1:0] addr;
        logic          wen;
        logic          err;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;

    logic [N-1:0] sel_data;
    logic         sel_err;
    entry_t       new_e;
    logic         accept;
    logic         drain;

    // Source select; an index with no matching source yields 0 and flags err.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < NSRC_U; k++) begin
            if (32'(sel) == k) begin
                sel_data = src_data[k*N +: N];
                sel_err  = 1'b0;
            end
        end
    end

    always_comb begin
        new_e.valid = 1'b1;
        new_e.data  = sel_data;
        new_e.addr  = rd_addr;
        // R0 is hardwired to zero, so a write to it is never requested.
        new_e.wen   = wr_en_in && (rd_addr != '0) && !sel_err;
        new_e.err   = sel_err;
    end

    assign in_ready = !s_q.valid;
    assign accept   = in_valid && in_ready;
    assign drain    = m_q.valid && out_ready;

    // S always holds the younger beat, so it refills M before any new input.
    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (!m_q.valid || drain) begin
            if (s_q.valid) begin
                m_d       = s_q;
                s_d.valid = 1'b0;
            end else if (accept) begin
                m_d = new_e;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = new_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign out_valid = m_q.valid;
    assign out_data  = m_q.data;
    assign out_addr  = m_q.addr;
    assign out_wr_en = m_q.valid && m_q.wen;
    assign out_err   = m_q.err;

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NSRC = 4 instance
    logic        in_valid, in_ready, out_valid, out_ready, wr_en_in, out_wr_en, out_err;
    logic [1:0]  sel;
    logic [63:0] src_data;
    logic [3:0]  rd_addr, out_addr;
    logic [15:0] out_data;

    // NSRC = 3 instance
    logic        in_valid3, in_ready3, out_valid3, out_ready3, wr_en_in3, out_wr_en3, out_err3;
    logic [1:0]  sel3;
    logic [47:0] src_data3;
    logic [3:0]  rd_addr3, out_addr3;
    logic [15:0] out_data3;

    int n_cmp = 0;
    int n_err = 0;

    wb_select_stage #(.N(16), .NSRC(4), .AW(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_data(src_data),
        .rd_addr(rd_addr), .wr_en_in(wr_en_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .out_wr_en(out_wr_en), .out_err(out_err)
    );

    wb_select_stage #(.N(16), .NSRC(3), .AW(4)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .src_data(src_data3),
        .rd_addr(rd_addr3), .wr_en_in(wr_en_in3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_addr(out_addr3),
        .out_wr_en(out_wr_en3), .out_err(out_err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        src_data  = {16'd40, 16'd30, 16'd20, 16'd10};
        src_data3 = {16'd30, 16'd20, 16'd10};
        in_valid  = 1'b1; sel  = 2'd0; rd_addr  = 4'd5; wr_en_in  = 1'b1; out_ready  = 1'b1;
        in_valid3 = 1'b0; sel3 = 2'd0; rd_addr3 = 4'd7; wr_en_in3 = 1'b1; out_ready3 = 1'b1;

        // Reset held for 3 cycles with in_valid asserted
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_addr",  32'(out_addr),  0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_out_err",   32'(out_err),   0);
        chk("rst_in_ready",  32'(in_ready),  1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("post_rst_no_beat", 32'(out_valid), 0);

        // Source sweep at full throughput
        in_valid = 1'b1; rd_addr = 4'd5; wr_en_in = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            chk("sweep_valid", 32'(out_valid), 1);
            chk("sweep_data",  32'(out_data),  32'(10 * (i + 1)));
            chk("sweep_wr_en", 32'(out_wr_en), 1);
            chk("sweep_addr",  32'(out_addr),  5);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_drained", 32'(out_valid), 0);

        // Backpressure: A held, B in skid, C stalled
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        tick();
        chk("bp_A_data",  32'(out_data), 10);
        chk("bp_A_ready", 32'(in_ready), 1);
        sel = 2'd1;
        tick();
        chk("bp_B_held_A",  32'(out_data), 10);
        chk("bp_B_ready",   32'(in_ready), 0);
        sel = 2'd2;
        tick();
        chk("bp_C_held_A",  32'(out_data),  10);
        chk("bp_C_valid",   32'(out_valid), 1);
        chk("bp_C_ready",   32'(in_ready),  0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_B",       32'(out_data), 20);
        chk("bp_ready_again", 32'(in_ready), 1);
        tick();
        chk("bp_out_C",       32'(out_data),  30);
        chk("bp_out_C_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(out_valid), 0);

        // R0 write suppression
        in_valid = 1'b1; rd_addr = 4'd0; wr_en_in = 1'b1; sel = 2'd2;
        tick();
        chk("r0_valid", 32'(out_valid), 1);
        chk("r0_data",  32'(out_data),  30);
        chk("r0_wr_en", 32'(out_wr_en), 0);
        in_valid = 1'b0;
        tick();

        // Invalid select on the NSRC = 3 instance
        in_valid3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("bad_valid", 32'(out_valid3), 1);
        chk("bad_data",  32'(out_data3),  0);
        chk("bad_err",   32'(out_err3),   1);
        chk("bad_wr_en", 32'(out_wr_en3), 0);
        sel3 = 2'd1;
        tick();
        chk("good_data",  32'(out_data3),  20);
        chk("good_err",   32'(out_err3),   0);
        chk("good_wr_en", 32'(out_wr_en3), 1);
        chk("good_addr",  32'(out_addr3),  7);
        sel3 = 2'd2;
        tick();
        chk("top_src_data", 32'(out_data3), 30);
        chk("top_src_err",  32'(out_err3),  0);
        in_valid3 = 1'b0;
        tick();

        // Mid-stall reset with both registers full
        out_ready = 1'b0; in_valid = 1'b1; rd_addr = 4'd3; sel = 2'd0;
        tick();
        sel = 2'd3;
        tick();
        chk("full_ready", 32'(in_ready),  0);
        chk("full_data",  32'(out_data),  10);
        chk("full_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_ready", 32'(in_ready),  1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("no_stale_1", 32'(out_valid), 0);
        tick();
        chk("no_stale_2", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
